// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers line/frame timing from hsync/vsync, tracks lock, reports visible pixels.
// Defining VGA_RX_FRAME_CRC_EN adds a CRC-16-CCITT over each locked frame's fg_hit bits.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_ACT_START = 144,
  parameter int H_VISIBLE   = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_START = 35,
  parameter int V_VISIBLE   = 480,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  R,
  input  logic [3:0]  G,
  input  logic [3:0]  B,
  input  logic [11:0] fgColor,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        fg_hit,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        frame_start,
  output logic        err_hline,
  output logic        err_vframe,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);
  localparam logic [10:0] H_TOT = H_TOTAL[10:0];
  localparam logic [10:0] H_LO  = H_ACT_START[10:0];
  localparam logic [10:0] H_HI  = H_LO + H_VISIBLE[10:0];
  localparam logic [9:0]  V_TOT = V_TOTAL[9:0];
  localparam logic [9:0]  V_LO  = V_ACT_START[9:0];
  localparam logic [9:0]  V_HI  = V_LO + V_VISIBLE[9:0];

  typedef enum logic [1:0] {UNLOCKED, TRAIN, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_q, vs_q, err_seen_q, err_seen_d;
  logic [10:0] h_cnt_q, h_cnt_d, line_len_q, h_off;
  logic [9:0]  v_cnt_q, v_cnt_d, frame_lines_q, v_off;
  logic        h_edge, v_edge, err_h, err_v;
  logic        pix_valid_d, fg_hit_d;
  logic [9:0]  pos_x_d, pos_y_d;
  logic        locked_q, pix_valid_q, fg_hit_q, frame_start_q, err_hline_q, err_vframe_q;
  logic [9:0]  pos_x_q, pos_y_q;

  always_comb begin
    h_edge = (hsync == SYNC_POL) && (hs_q != SYNC_POL);
    v_edge = (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    err_h  = h_edge && (state_q != UNLOCKED) && ((h_cnt_q + 11'd1) != H_TOT);
    err_v  = v_edge && (state_q != UNLOCKED) && ((v_cnt_q + 10'd1) != V_TOT);

    h_cnt_d = h_edge ? 11'd0 : ((h_cnt_q == 11'h7FF) ? h_cnt_q : h_cnt_q + 11'd1);
    v_cnt_d = v_cnt_q;
    if (v_edge)                           v_cnt_d = 10'd0;
    else if (h_edge && v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;

    // A line error seen mid-frame taints the frame in progress, so relock needs one clean frame after it.
    state_d    = state_q;
    err_seen_d = err_seen_q;
    if (v_edge) begin
      err_seen_d = 1'b0;
      case (state_q)
        UNLOCKED: state_d = TRAIN;
        TRAIN:    state_d = (err_seen_q || err_h || err_v) ? TRAIN : LOCKED;
        default:  state_d = (err_h || err_v) ? TRAIN : LOCKED;
      endcase
    end else if (err_h) begin
      err_seen_d = 1'b1;
      if (state_q == LOCKED) state_d = TRAIN;
    end

    pix_valid_d = (state_d == LOCKED) && (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) &&
                  (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
    h_off   = h_cnt_d - H_LO;
    v_off   = v_cnt_d - V_LO;
    pos_x_d = pix_valid_d ? h_off[9:0] : 10'd0;
    pos_y_d = pix_valid_d ? v_off : 10'd0;
    fg_hit_d = pix_valid_d && ({R, G, B} == fgColor);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UNLOCKED;
      err_seen_q    <= 1'b0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 10'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 10'd0;
      locked_q      <= 1'b0;
      pix_valid_q   <= 1'b0;
      pos_x_q       <= 10'd0;
      pos_y_q       <= 10'd0;
      fg_hit_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_hline_q   <= 1'b0;
      err_vframe_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      err_hline_q   <= 1'b0;
      err_vframe_q  <= 1'b0;
      if (en) begin
        hs_q          <= hsync;
        vs_q          <= vsync;
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        state_q       <= state_d;
        err_seen_q    <= err_seen_d;
        locked_q      <= (state_d == LOCKED);
        pix_valid_q   <= pix_valid_d;
        pos_x_q       <= pos_x_d;
        pos_y_q       <= pos_y_d;
        fg_hit_q      <= fg_hit_d;
        frame_start_q <= v_edge;
        err_hline_q   <= err_h;
        err_vframe_q  <= err_v;
        if (h_edge) line_len_q    <= h_cnt_q + 11'd1;
        if (v_edge) frame_lines_q <= v_cnt_q + 10'd1;
      end
    end
  end

  assign locked      = locked_q;
  assign pix_valid   = pix_valid_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign fg_hit      = fg_hit_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_start = frame_start_q;
  assign err_hline   = err_hline_q;
  assign err_vframe  = err_vframe_q;

`ifdef VGA_RX_FRAME_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q;
  logic        crc_valid_q;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_comb begin
    crc_d = v_edge ? 16'hFFFF : crc_q;
    if (state_d != LOCKED) crc_d = 16'hFFFF;
    else if (pix_valid_d)  crc_d = crc_step(crc_d, fg_hit_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= 16'h0000;
      crc_valid_q <= 1'b0;
    end else begin
      crc_valid_q <= 1'b0;
      if (en) begin
        crc_q <= crc_d;
        if (v_edge && state_q == LOCKED) begin
          frame_crc_q <= crc_q;
          crc_valid_q <= 1'b1;
        end
      end
    end
  end

  assign frame_crc = frame_crc_q;
  assign crc_valid = crc_valid_q;
`else
  assign frame_crc = 16'h0000;
  assign crc_valid = 1'b0;
`endif
endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a scaled-down 20x12 timing; per-cycle reference model plus literal checks.
module tb_vga_rx_monitor;
  localparam int HT = 20, HAS = 4, HV = 12, VT = 12, VAS = 3, VV = 6;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0, reset = 1'b1, en = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [3:0]  R = 4'h0, G = 4'h0, B = 4'h0;
  logic [11:0] fgColor = 12'hFFF;
  logic        locked, pix_valid, fg_hit, frame_start, err_hline, err_vframe, crc_valid;
  logic [9:0]  pos_x, pos_y, frame_lines;
  logic [10:0] line_len;
  logic [15:0] frame_crc;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_ACT_START(HAS), .H_VISIBLE(HV),
    .V_TOTAL(VT), .V_ACT_START(VAS), .V_VISIBLE(VV), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
    .R(R), .G(G), .B(B), .fgColor(fgColor),
    .locked(locked), .pix_valid(pix_valid), .pos_x(pos_x), .pos_y(pos_y), .fg_hit(fg_hit),
    .line_len(line_len), .frame_lines(frame_lines), .frame_start(frame_start),
    .err_hline(err_hline), .err_vframe(err_vframe), .frame_crc(frame_crc), .crc_valid(crc_valid)
  );

  int vectors = 0, fails = 0;

  // reference model state (integers, lock state 0=unlocked 1=training 2=locked)
  int m_h, m_v, m_st;
  bit m_seen, m_phs, m_pvs;
  logic [15:0] m_crc;
  bit e_locked, e_pv, e_fg, e_fs, e_eh, e_ev, e_cv;
  int e_px, e_py, e_ll, e_fl;
  logic [15:0] e_fcrc;

  // observations of DUT behaviour for the literal checks
  int n_pv, n_hit, n_eh, n_ev, n_fs, n_cv, max_x, max_y, first_x, first_y, hit_x, hit_y, err_ll;
  logic [15:0] crcq[$];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  // CRC of one frame where only visible pixel (10,5) is foreground, in raster order
  function automatic logic [15:0] golden_crc();
    logic [15:0] c = 16'hFFFF;
    for (int y = 0; y < VV; y++)
      for (int x = 0; x < HV; x++)
        c = crc_step(c, (x == 10) && (y == 5));
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_st = 0; m_seen = 0; m_phs = ~POL; m_pvs = ~POL; m_crc = 16'hFFFF;
    e_locked = 0; e_pv = 0; e_fg = 0; e_fs = 0; e_eh = 0; e_ev = 0; e_cv = 0;
    e_px = 0; e_py = 0; e_ll = 0; e_fl = 0; e_fcrc = 16'h0000;
  endtask

  task automatic model_step(input bit hs, input bit vs, input logic [11:0] rgb);
    bit he, ve;
    int ost;
    logic [15:0] base;
    he  = (hs == POL) && (m_phs != POL);
    ve  = (vs == POL) && (m_pvs != POL);
    m_phs = hs; m_pvs = vs;
    ost = m_st;
    e_eh = he && ost != 0 && (((m_h + 1) % 2048) != HT);
    e_ev = ve && ost != 0 && (((m_v + 1) % 1024) != VT);
    if (he) e_ll = (m_h + 1) % 2048;
    if (ve) e_fl = (m_v + 1) % 1024;
    if (he) m_h = 0; else if (m_h < 2047) m_h++;
    if (ve) m_v = 0; else if (he && m_v < 1023) m_v++;
    if (ve) begin
      if (ost == 0)      m_st = 1;
      else if (ost == 1) m_st = (m_seen || e_eh || e_ev) ? 1 : 2;
      else               m_st = (e_eh || e_ev) ? 1 : 2;
      m_seen = 0;
    end else if (e_eh) begin
      m_seen = 1;
      if (ost == 2) m_st = 1;
    end
    e_locked = (m_st == 2);
    e_pv = e_locked && m_h >= HAS && m_h < HAS + HV && m_v >= VAS && m_v < VAS + VV;
    e_px = e_pv ? m_h - HAS : 0;
    e_py = e_pv ? m_v - VAS : 0;
    e_fg = e_pv && (rgb == fgColor);
    e_fs = ve;
`ifdef VGA_RX_FRAME_CRC_EN
    e_cv = ve && ost == 2;
    if (e_cv) e_fcrc = m_crc;
    base = ve ? 16'hFFFF : m_crc;
    if (m_st != 2) m_crc = 16'hFFFF;
    else if (e_pv) m_crc = crc_step(base, e_fg);
    else m_crc = base;
`else
    base = 16'h0000;
    e_cv = 0;
    m_crc = base;
`endif
  endtask

  task automatic check_outputs();
    chk("locked", locked, e_locked);
    chk("pix_valid", pix_valid, e_pv);
    chk("pos_x", pos_x, e_px);
    chk("pos_y", pos_y, e_py);
    chk("fg_hit", fg_hit, e_fg);
    chk("line_len", line_len, e_ll);
    chk("frame_lines", frame_lines, e_fl);
    chk("frame_start", frame_start, e_fs);
    chk("err_hline", err_hline, e_eh);
    chk("err_vframe", err_vframe, e_ev);
    chk("frame_crc", frame_crc, e_fcrc);
    chk("crc_valid", crc_valid, e_cv);
  endtask

  task automatic clr_obs();
    n_pv = 0; n_hit = 0; n_eh = 0; n_ev = 0; n_fs = 0; n_cv = 0;
    max_x = -1; max_y = -1; first_x = -1; first_y = -1; hit_x = -1; hit_y = -1; err_ll = -1;
    crcq.delete();
  endtask

  task automatic observe(input bit e);
    if (frame_start) n_fs++;
    if (err_hline) begin n_eh++; err_ll = int'(line_len); end
    if (err_vframe) n_ev++;
    if (crc_valid) begin n_cv++; crcq.push_back(frame_crc); end
    if (e && pix_valid) begin
      n_pv++;
      if (first_x < 0) begin first_x = int'(pos_x); first_y = int'(pos_y); end
      if (int'(pos_x) > max_x) max_x = int'(pos_x);
      if (int'(pos_y) > max_y) max_y = int'(pos_y);
    end
    if (e && fg_hit) begin n_hit++; hit_x = int'(pos_x); hit_y = int'(pos_y); end
  endtask

  task automatic cycle(input bit e, input bit hs, input bit vs, input logic [11:0] rgb);
    en = e; hsync = hs; vsync = vs; {R, G, B} = rgb;
    if (e && !reset) model_step(hs, vs, rgb);
    else begin e_fs = 0; e_eh = 0; e_ev = 0; e_cv = 0; end
    @(posedge clk); #1;
    check_outputs();
    observe(e);
  endtask

  task automatic send_frame(input int every, input int short_line, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        bit hs, vs;
        logic [11:0] rgb;
        hs  = (p < 2) ? POL : ~POL;
        vs  = (l < 2) ? POL : ~POL;
        rgb = (p - HAS == 10 && l - VAS == 5) ? 12'hFFF : 12'h3A5;
        cycle(1'b1, hs, vs, rgb);
        for (int k = 1; k < every; k++) cycle(1'b0, hs, vs, rgb);
      end
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; #1;
    model_reset();
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_line_len"}, line_len, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_frame_crc"}, frame_crc, 0);
    cycle(1'b0, ~POL, ~POL, 12'h000);
    cycle(1'b0, ~POL, ~POL, 12'h000);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // basic timing, lock at second vsync edge, visible window and single fg pixel
    clr_obs();
    send_frame(1, -1, VT);
    chk("t1_unlocked_after_f0", locked, 0);
    clr_obs();
    send_frame(1, -1, VT);
    chk("t1_locked", locked, 1);
    chk("t1_line_len", line_len, 20);
    chk("t1_frame_lines", frame_lines, 12);
    chk("t1_no_err", n_eh + n_ev, 0);
    chk("t2_pv_count", n_pv, HV * VV);
    chk("t2_first_pos", {first_x[15:0], first_y[15:0]}, 32'h0000_0000);
    chk("t2_max_x", max_x, 11);
    chk("t2_max_y", max_y, 5);
    chk("t4_hits", n_hit, 1);
    chk("t4_hit_pos", {hit_x[15:0], hit_y[15:0]}, {16'd10, 16'd5});

    // one 19-cycle line while locked
    clr_obs();
    send_frame(1, 9, VT);
    chk("t3_err_count", n_eh, 1);
    chk("t3_err_line_len", err_ll, 19);
    chk("t3_unlocked", locked, 0);
    send_frame(1, -1, VT);
    chk("t3_still_training", locked, 0);
    send_frame(1, -1, VT);
    chk("t3_relocked", locked, 1);
    chk("t3_total_err", n_eh + n_ev, 1);

    // en 1-in-4
    do_reset("t5rst");
    clr_obs();
    send_frame(4, -1, VT);
    clr_obs();
    send_frame(4, -1, VT);
    chk("t5_locked", locked, 1);
    chk("t5_line_len", line_len, 20);
    chk("t5_frame_lines", frame_lines, 12);
    chk("t5_frame_start", n_fs, 1);
    chk("t5_pv_count", n_pv, HV * VV);
    chk("t5_hits", n_hit, 1);

    // mid-frame reset, then frames for the CRC
    send_frame(1, -1, 7);
    chk("t6_locked_before", locked, 1);
    do_reset("t6rst");
    clr_obs();
    for (int f = 0; f < 5; f++) send_frame(1, -1, VT);
    chk("t6_relocked", locked, 1);
    chk("t6_no_err", n_eh + n_ev, 0);
`ifdef VGA_RX_FRAME_CRC_EN
    chk("t6_crc_pulses", n_cv, 3);
    if (crcq.size() >= 2) begin
      chk("t6_crc_equal", crcq[1], crcq[0]);
      chk("t6_crc_golden", crcq[0], golden_crc());
    end else chk("t6_crc_missing", crcq.size(), 2);
`else
    chk("t6_crc_pulses", n_cv, 0);
    chk("t6_frame_crc_tied", frame_crc, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
